// File: rtl/alu_iter_if.sv
// -----------------------------------------------------------------------------
// alu_iter_if
// Purpose : groups the request/response signals of the iterative ALU so the
//           requester and the ALU connect through a single port.
// Signals : start  - request, sampled on a clk edge while busy=0
//           gin    - 3-bit ALU control code
//           a, b   - operands (b is also the shift source)
//           shamt  - shift amount
//           busy   - high while a multi-cycle shift is iterating
//           done   - one-cycle completion pulse
//           result - registered result, held until the next completion
//           zout   - registered (result == 0)
// Modports: master drives the request side, slave (the ALU) drives the
//           response side.
// -----------------------------------------------------------------------------
interface alu_iter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [2:0]         gin;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               zout;

  modport master (
    output start, gin, a, b, shamt,
    input  busy, done, result, zout
  );

  modport slave (
    input  start, gin, a, b, shamt,
    output busy, done, result, zout
  );
endinterface

// File: rtl/alu_iter.sv
// -----------------------------------------------------------------------------
// alu_iter
// Purpose : multi-cycle integer ALU fed by the ALU control decoder.
//           add/sub/and/or/slt finish in one cycle; srl shifts right one bit per
//           cycle on an iterative shifter (no barrel shifter in the datapath).
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - alu_iter_if.slave (start/gin/a/b/shamt in,
//                   busy/done/result/zout out)
// Codes   : 010 add, 110 sub, 000 and, 001 or, 111 slt (signed), 011 srl.
//           100/101 give result=0, zout=1 in one cycle.
// Config  : define ALU_SRA_EN to make gin=100 an arithmetic right shift (sra)
//           sharing the srl iteration path and latency.
// Latency : 1 edge for non-shift ops and for shifts by 0 or 1; shamt edges for
//           shifts by 2 or more.
// -----------------------------------------------------------------------------
module alu_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_iter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_zout;

  logic               w_accept;
  logic               w_is_shift;
  logic               w_long;
  logic               w_fill_in;
  logic               w_fill_cur;
  logic [WIDTH-1:0]   w_fast;
  logic [WIDTH-1:0]   w_acc_nxt;

  // One-bit right shift with a caller-supplied fill bit (0 for srl, sign for sra).
  function automatic logic [WIDTH-1:0] f_shr1(input logic [WIDTH-1:0] v,
                                              input logic fill);
    return {fill, v[WIDTH-1:1]};
  endfunction

  // Single-cycle results; shifts only reach here with shamt of 0 or 1,
  // so shamt[0] alone selects between pass-through and a one-bit shift.
  function automatic logic [WIDTH-1:0] f_fast(input logic [2:0]       g,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             sh1);
    case (g)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011:  return sh1 ? {1'b0, b[WIDTH-1:1]} : b;
`ifdef ALU_SRA_EN
      3'b100:  return sh1 ? {b[WIDTH-1], b[WIDTH-1:1]} : b;
`endif
      default: return '0;
    endcase
  endfunction

  assign w_accept = bus.start && (r_state != S_SHIFT);

`ifdef ALU_SRA_EN
  logic r_fill;

  assign w_is_shift = (bus.gin == 3'b011) || (bus.gin == 3'b100);
  assign w_fill_in  = (bus.gin == 3'b100) && bus.b[WIDTH-1];
  assign w_fill_cur = r_fill;

  // Sign fill is constant for the whole shift, so it is captured once at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= 1'b0;
    end else if (w_accept) begin
      r_fill <= w_fill_in;
    end
  end
`else
  assign w_is_shift = (bus.gin == 3'b011);
  assign w_fill_in  = 1'b0;
  assign w_fill_cur = 1'b0;
`endif

  // Shifts by 2+ iterate; the accept edge already performs the first bit.
  assign w_long    = w_is_shift && (bus.shamt > SHAMT_W'(1));
  assign w_fast    = f_fast(bus.gin, bus.a, bus.b, bus.shamt[0]);
  assign w_acc_nxt = f_shr1(r_acc, w_fill_cur);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (w_long) begin
              r_acc   <= f_shr1(bus.b, w_fill_in);
              r_cnt   <= bus.shamt - SHAMT_W'(1);
              r_state <= S_SHIFT;
            end else begin
              r_result <= w_fast;
              r_zout   <= (w_fast == '0);
              r_state  <= S_DONE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - SHAMT_W'(1);
          // Last remaining bit: commit the final shifted value directly.
          if (r_cnt == SHAMT_W'(1)) begin
            r_result <= w_acc_nxt;
            r_zout   <= (w_acc_nxt == '0);
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state == S_SHIFT);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;
  assign bus.zout   = r_zout;

endmodule
